// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator.
//   state_e       : controller states (idle, accumulating, requantizing)
//   PSUM_W        : width of incoming partial sums and bias
//   OFMAP_W       : width of the unsigned output activation
//   ACC_W_DEFAULT : default signed accumulator width
//   OFMAP_MAX     : largest representable output activation
//   sat_max/min   : signed saturation bounds for an accumulator of width w
package psum_accumulator_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StQuant
  } state_e;

  localparam int unsigned PSUM_W        = 20;
  localparam int unsigned OFMAP_W       = 8;
  localparam int unsigned ACC_W_DEFAULT = 24;
  localparam int unsigned OFMAP_MAX     = 255;

  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/ofmap_fifo.sv
// Show-ahead output FIFO with count-based full/empty.
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : write wdata_i (ignored when full)
//   wdata_i   : entry to enqueue
//   pop_i     : drop the head entry (ignored when empty)
//   rdata_o   : head entry, zero when empty
//   full_o    : registered count equals Depth
//   empty_o   : registered count is zero
module ofmap_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

  // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates framed partial sums from a PE column tail into one output pixel, adds a bias
// on the opening beat, saturates to ACC_W bits, requantizes with a rounding right shift to
// an unsigned 8-bit activation and queues the result in a small output FIFO.
//   clk, rst     : clock, asynchronous active-high reset
//   psum_valid   : partial-sum beat offered
//   psum_ready   : beat accepted this cycle (low while requantizing)
//   psum_in      : signed partial sum
//   psum_first   : beat opens a new pixel (bias sampled with it)
//   psum_last    : beat closes the current pixel
//   bias         : signed bias
//   shift        : requantization right shift, held static while busy
//   ofmap_valid  : FIFO head valid
//   ofmap_ready  : consumer pops the head
//   ofmap_data   : unsigned activation at FIFO head
//   ovf_flag     : sticky, accumulator saturated
//   err_flag     : sticky, framing violation
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W      = ACC_W_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               psum_valid,
  output logic               psum_ready,
  input  logic [PSUM_W-1:0]  psum_in,
  input  logic               psum_first,
  input  logic               psum_last,
  input  logic [PSUM_W-1:0]  bias,
  input  logic [3:0]         shift,
  output logic               ofmap_valid,
  input  logic               ofmap_ready,
  output logic [OFMAP_W-1:0] ofmap_data,
  output logic               ovf_flag,
  output logic               err_flag
);

  // One guard bit above the accumulator so sums and rounding never wrap before clamping.
  localparam int unsigned SumW = ACC_W + 1;
  localparam longint AccMaxL = sat_max(ACC_W);
  localparam longint AccMinL = sat_min(ACC_W);
  localparam logic signed [SumW-1:0] AccMax = AccMaxL[SumW-1:0];
  localparam logic signed [SumW-1:0] AccMin = AccMinL[SumW-1:0];
  localparam logic signed [SumW-1:0] QMax   = SumW'(OFMAP_MAX);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic                    err_q, err_d;

  logic                    beat_fire;
  logic                    fifo_push, fifo_full, fifo_empty;

  logic signed [SumW-1:0]  psum_ext, bias_ext, acc_ext;
  logic signed [SumW-1:0]  sum, sum_sat;
  logic                    sum_clamped;
  logic signed [SumW-1:0]  rnd, rounded, shifted;
  logic                    acc_nonpos;
  logic [OFMAP_W-1:0]      q;

  assign psum_ready = (state_q != StQuant);
  assign beat_fire  = psum_valid && psum_ready;

  assign psum_ext = SumW'($signed(psum_in));
  assign bias_ext = SumW'($signed(bias));
  assign acc_ext  = SumW'(acc_q);

  // A first beat always restarts from bias, whatever was accumulated before.
  assign sum = psum_first ? (psum_ext + bias_ext) : (acc_ext + psum_ext);

  always_comb begin
    sum_sat     = sum;
    sum_clamped = 1'b0;
    if (sum > AccMax) begin
      sum_sat     = AccMax;
      sum_clamped = 1'b1;
    end else if (sum < AccMin) begin
      sum_sat     = AccMin;
      sum_clamped = 1'b1;
    end
  end

  // Round half up: add 2^(shift-1) before the arithmetic shift.
  assign rnd        = (shift == 4'd0) ? '0 : (SumW'(1) << (shift - 4'd1));
  assign rounded    = acc_ext + rnd;
  assign shifted    = rounded >>> shift;
  assign acc_nonpos = acc_q[ACC_W-1] || (acc_q == '0);

  always_comb begin
    q = '0;
    if (acc_nonpos) begin
      q = '0;
    end else if (shifted > QMax) begin
      q = OFMAP_W'(OFMAP_MAX);
    end else begin
      q = shifted[OFMAP_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    fifo_push = 1'b0;

    case (state_q)
      StIdle, StAcc: begin
        if (beat_fire) begin
          if (!psum_first && (state_q == StIdle)) begin
            // Continuation beat with no open pixel: drop it.
            err_d = 1'b1;
          end else begin
            if (psum_first && (state_q == StAcc)) begin
              err_d = 1'b1;
            end
            acc_d   = sum_sat[ACC_W-1:0];
            ovf_d   = ovf_q || sum_clamped;
            state_d = psum_last ? StQuant : StAcc;
          end
        end
      end

      StQuant: begin
        // Retry every cycle until the FIFO has room; acc holds meanwhile.
        if (!fifo_full) begin
          fifo_push = 1'b1;
          state_d   = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign ovf_flag    = ovf_q;
  assign err_flag    = err_q;
  assign ofmap_valid = !fifo_empty;

  ofmap_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(OFMAP_W)
  ) u_ofmap_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifo_push),
    .wdata_i(q),
    .pop_i  (ofmap_ready),
    .rdata_o(ofmap_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule
